// File: rtl/bounce_gen.sv
// Programmable contact-bounce / glitch generator: turns clean level changes on sig_in
// into LFSR-driven toggle bursts followed by a settled level on a registered sig_out.
module bounce_gen #(
  parameter int         BOUNCE_MAX = 7,
  parameter int         HOLD_W     = 2,
  parameter int         SETTLE_CYC = 8,
  parameter logic [7:0] SEED       = 8'hA5
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic       glitch_en,
  input  logic       sig_in,
  output logic       sig_out,
  output logic       busy,
  output logic [7:0] edge_cnt
);

  localparam logic [7:0]    LFSR_INIT   = (SEED == 8'h00) ? 8'h01 : SEED;
  localparam int            SW          = $clog2(SETTLE_CYC + 1);
  localparam logic [3:0]    BMAX        = 4'(BOUNCE_MAX);
  localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYC - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BOUNCE = 2'd1,
    SETTLE = 2'd2
  } state_t;

  // Fibonacci step for x^8+x^6+x^5+x^4+1
  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  state_t             state_r, state_s;
  logic               sig_q_r;
  logic               level_r, level_s;
  logic               sig_out_r, sig_out_s;
  logic               busy_r;
  logic [7:0]         edge_cnt_r, edge_cnt_s;
  logic [7:0]         lfsr_r;
  logic [3:0]         toggles_r, toggles_s;
  logic [HOLD_W-1:0]  hold_r, hold_s;
  logic [SW-1:0]      settle_r, settle_s;
  logic [3:0]         burst_n_s;

  // Next-state and next-output decode
  always_comb begin
    state_s    = state_r;
    level_s    = level_r;
    sig_out_s  = sig_out_r;
    edge_cnt_s = edge_cnt_r;
    toggles_s  = toggles_r;
    hold_s     = hold_r;
    settle_s   = settle_r;
    burst_n_s  = (lfsr_r[3:0] > BMAX) ? BMAX : lfsr_r[3:0];
    if (!enable) begin
      state_s   = IDLE;
      sig_out_s = sig_q_r;
      level_s   = sig_q_r;
    end else begin
      case (state_r)
        IDLE: begin
          if (sig_q_r != level_r) begin
            sig_out_s = ~level_r;
            if (burst_n_s == 4'd0) begin
              state_s  = SETTLE;
              settle_s = SETTLE_LOAD;
            end else begin
              state_s   = BOUNCE;
              toggles_s = burst_n_s - 4'd1;
              hold_s    = lfsr_r[HOLD_W-1:0];
            end
          // a glitch never stretches past one cycle, even on back-to-back F nibbles
          end else if (glitch_en && (lfsr_r[7:4] == 4'hF) && (sig_out_r == level_r)) begin
            sig_out_s = ~level_r;
          end else begin
            sig_out_s = level_r;
          end
        end
        BOUNCE: begin
          if (hold_r != {HOLD_W{1'b0}}) begin
            hold_s = hold_r - HOLD_W'(1);
          end else if (toggles_r != 4'd0) begin
            sig_out_s = ~sig_out_r;
            toggles_s = toggles_r - 4'd1;
            hold_s    = lfsr_r[HOLD_W-1:0];
          end else begin
            state_s   = SETTLE;
            settle_s  = SETTLE_LOAD;
            sig_out_s = ~level_r;
          end
        end
        SETTLE: begin
          sig_out_s = ~level_r;
          if (settle_r != {SW{1'b0}}) begin
            settle_s = settle_r - SW'(1);
          end else begin
            state_s    = IDLE;
            level_s    = ~level_r;
            edge_cnt_s = edge_cnt_r + 8'd1;
          end
        end
        default: begin
          state_s   = IDLE;
          sig_out_s = level_r;
        end
      endcase
    end
  end

  // State, input synchroniser and output registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r    <= IDLE;
      sig_q_r    <= 1'b0;
      level_r    <= 1'b0;
      sig_out_r  <= 1'b0;
      busy_r     <= 1'b0;
      edge_cnt_r <= 8'd0;
      lfsr_r     <= LFSR_INIT;
      toggles_r  <= 4'd0;
      hold_r     <= {HOLD_W{1'b0}};
      settle_r   <= {SW{1'b0}};
    end else begin
      sig_q_r    <= sig_in;
      state_r    <= state_s;
      level_r    <= level_s;
      sig_out_r  <= sig_out_s;
      busy_r     <= (state_s != IDLE);
      edge_cnt_r <= edge_cnt_s;
      toggles_r  <= toggles_s;
      hold_r     <= hold_s;
      settle_r   <= settle_s;
      if (enable) begin
        lfsr_r <= lfsr_step(lfsr_r);
      end else begin
        lfsr_r <= lfsr_r;
      end
    end
  end

  assign sig_out  = sig_out_r;
  assign busy     = busy_r;
  assign edge_cnt = edge_cnt_r;

endmodule

// File: tb/tb_bounce_gen.sv
// Scoreboard bench for bounce_gen: a burst-planning reference model pushes the expected
// sig_out/busy/edge_cnt per cycle; a negedge monitor pops and compares.
module tb_bounce_gen;

  localparam int         BMAX = 7;
  localparam int         HW   = 2;
  localparam int         SC   = 8;
  localparam logic [7:0] SEED = 8'hA5;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       glitch_en = 1'b0;
  logic       sig_in = 1'b0;
  logic       sig_out, busy;
  logic [7:0] edge_cnt;

  logic       sig_in2 = 1'b0;
  logic       sig_out2, busy2;
  logic [7:0] edge_cnt2;

  int vectors = 0;
  int miscompares = 0;

  bounce_gen #(.BOUNCE_MAX(BMAX), .HOLD_W(HW), .SETTLE_CYC(SC), .SEED(SEED)) dut (
    .clock(clock), .reset(reset), .enable(enable), .glitch_en(glitch_en),
    .sig_in(sig_in), .sig_out(sig_out), .busy(busy), .edge_cnt(edge_cnt));

  bounce_gen #(.BOUNCE_MAX(0), .HOLD_W(HW), .SETTLE_CYC(SC), .SEED(SEED)) dut_clean (
    .clock(clock), .reset(reset), .enable(1'b1), .glitch_en(1'b0),
    .sig_in(sig_in2), .sig_out(sig_out2), .busy(busy2), .edge_cnt(edge_cnt2));

  always #5 clock = ~clock;

  // ---------------- reference model ----------------
  typedef struct packed {logic out; logic busy; logic fin;} plan_t;
  typedef struct packed {logic out; logic busy; logic [7:0] cnt;} exp_t;

  plan_t      plan_q[$];
  exp_t       exp_q[$];
  logic       m_sq, m_lvl, m_out, m_busy;
  logic [7:0] m_cnt, m_lfsr;

  function automatic logic [7:0] nxt(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  task automatic model_reset();
    plan_q.delete();
    exp_q.delete();
    m_sq = 1'b0; m_lvl = 1'b0; m_out = 1'b0; m_busy = 1'b0;
    m_cnt = 8'd0; m_lfsr = SEED;
  endtask

  // Lay out the whole burst, one entry per cycle, from the LFSR values it will see.
  task automatic build_plan(input logic [7:0] l0);
    int n, h;
    logic v;
    logic [7:0] l;
    n = (int'(l0[3:0]) < BMAX) ? int'(l0[3:0]) : BMAX;
    v = ~m_lvl;
    l = l0;
    for (int i = 0; i < n; i++) begin
      h = int'(l) % (1 << HW);
      for (int k = 0; k <= h; k++) begin
        plan_q.push_back(plan_t'{v, 1'b1, 1'b0});
        l = nxt(l);
      end
      v = ~v;
    end
    for (int k = 0; k < SC; k++) plan_q.push_back(plan_t'{~m_lvl, 1'b1, 1'b0});
    plan_q.push_back(plan_t'{~m_lvl, 1'b0, 1'b1});
  endtask

  task automatic model_step();
    plan_t p;
    if (!enable) begin
      plan_q.delete();
      m_out = m_sq; m_lvl = m_sq; m_busy = 1'b0;
    end else begin
      if (plan_q.size() == 0 && m_sq != m_lvl) build_plan(m_lfsr);
      if (plan_q.size() > 0) begin
        p = plan_q.pop_front();
        m_out = p.out; m_busy = p.busy;
        if (p.fin) begin
          m_lvl = ~m_lvl;
          m_cnt = m_cnt + 8'd1;
        end
      end else begin
        m_busy = 1'b0;
        if (glitch_en && m_lfsr[7:4] == 4'hF && m_out == m_lvl) m_out = ~m_lvl;
        else m_out = m_lvl;
      end
      m_lfsr = nxt(m_lfsr);
    end
    m_sq = sig_in;
    exp_q.push_back(exp_t'{m_out, m_busy, m_cnt});
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clock or posedge reset);
      if (reset) model_reset();
      else model_step();
    end
  end

  // ---------------- monitor ----------------
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (!reset && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        vectors++;
        if ({sig_out, busy, edge_cnt} !== e) begin
          miscompares++;
          $display("FAIL scoreboard t=%0t got sig_out=%b busy=%b edge_cnt=%0d want sig_out=%b busy=%b edge_cnt=%0d",
                   $time, sig_out, busy, edge_cnt, e.out, e.busy, e.cnt);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic check(input string name, input int got, input int want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  initial begin
    int busy_cycles, edges, glitches, bcnt;
    logic prev;
    logic [7:0] c0;

    tick(2);
    reset = 1'b0;
    tick(3);

    // clean-edge instance: rise exactly two edges after sig_in, then SETTLE_CYC busy cycles
    sig_in2 = 1'b1;
    tick(1);
    check("clean_lat1", int'(sig_out2), 0);
    tick(1);
    check("clean_lat2", int'(sig_out2), 1);
    bcnt = int'(busy2);
    edges = 0;
    prev = sig_out2;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      bcnt += int'(busy2);
      if (sig_out2 != prev) edges++;
      prev = sig_out2;
    end
    check("clean_busy", bcnt, SC);
    check("clean_edges", edges, 0);
    check("clean_cnt", int'(edge_cnt2), 1);

    // bypass
    sig_in = 1'b1; tick(5);
    sig_in = 1'b0; tick(5);
    check("bypass_cnt", int'(edge_cnt), 0);

    // single burst 0->1
    enable = 1'b1;
    tick(3);
    sig_in = 1'b1;
    busy_cycles = 0;
    for (int i = 0; i < 80; i++) begin
      tick(1);
      busy_cycles += int'(busy);
    end
    check("burst_len_max", int'(busy_cycles <= 2 + BMAX * (1 << HW) + SC), 1);
    check("burst_len_min", int'(busy_cycles >= SC), 1);
    check("burst_final", int'(sig_out), 1);
    check("burst_cnt", int'(edge_cnt), 1);

    // async reset in the middle of a burst
    sig_in = 1'b0;
    tick(4);
    #2;
    reset = 1'b1;
    #1;
    check("rst_sig_out", int'(sig_out), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_cnt", int'(edge_cnt), 0);
    check("rst_clean_cnt", int'(edge_cnt2), 0);
    tick(2);
    reset = 1'b0;
    tick(5);

    // short pulse: two bursts, final level restored
    c0 = m_cnt;
    sig_in = 1'b1; tick(2);
    sig_in = 1'b0; tick(150);
    check("pulse_cnt", int'(edge_cnt), int'(c0 + 8'd2));
    check("pulse_final", int'(sig_out), 0);

    // glitches on a steady low level
    glitch_en = 1'b1;
    glitches = 0;
    prev = sig_out;
    for (int i = 0; i < 1024; i++) begin
      tick(1);
      if (sig_out && !prev) glitches++;
      prev = sig_out;
    end
    check("glitch_seen", int'(glitches > 0), 1);

    // random traffic
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(39, 0) == 0) sig_in = ~sig_in;
      if ($urandom_range(199, 0) == 0) enable = ~enable;
      if ($urandom_range(99, 0) == 0) glitch_en = ~glitch_en;
      tick(1);
    end
    enable = 1'b1;
    tick(60);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
